// File: rtl/mem_arbiter_n_pkg.sv
// Shared types and constants for the N-channel memory arbiter.
package mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      DONE
   } state_t;

   typedef enum logic {
      OP_READ,
      OP_WRITE
   } op_t;

   localparam int ARB_MODE_RR    = 0;
   localparam int ARB_MODE_FIXED = 1;

   // Pointer/index width; a single channel still needs one bit.
   function automatic int ptr_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/mem_arbiter_n_if.sv
// External memory port: one read/write strobe pair completed by mem_ack.
interface mem_arbiter_n_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) ();

   logic              mem_read;
   logic              mem_write;
   logic              mem_ack;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_data_write;
   logic [DATA_W-1:0] mem_data_read;

   modport master (
      output mem_read, mem_write, mem_addr, mem_data_write,
      input  mem_ack, mem_data_read
   );

   modport slave (
      input  mem_read, mem_write, mem_addr, mem_data_write,
      output mem_ack, mem_data_read
   );

endinterface

// File: rtl/mem_arbiter_n_rr_pick.sv
// Combinational rotating-priority picker; fixed mode searches from index 0.
module rr_pick #(
   parameter int NUM_CH = 2,
   parameter int PTR_W  = 1
) (
   input  logic [NUM_CH-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   input  logic              mode,
   output logic [NUM_CH-1:0] onehot,
   output logic [PTR_W-1:0]  idx,
   output logic              valid
);

   int unsigned c;

   always_comb begin
      onehot = '0;
      idx    = '0;
      valid  = 1'b0;
      c      = 0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
         c = mode ? i : (i + 32'(ptr)) % NUM_CH;
         if (!valid && req[c]) begin
            valid     = 1'b1;
            onehot[c] = 1'b1;
            idx       = PTR_W'(c);
         end
      end
   end

endmodule

// File: rtl/mem_arbiter_n.sv
// N-channel memory arbiter, round-robin or fixed priority, registered outputs.
// Optional ISSUE timeout enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter_n
   import mem_arb_pkg::*;
#(
   parameter int NUM_CH         = 2,
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int ARB_MODE       = 0,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NUM_CH-1:0]        ch_read_req,
   input  logic [NUM_CH-1:0]        ch_write_req,
   input  logic [NUM_CH*ADDR_W-1:0] ch_addr,
   input  logic [NUM_CH*DATA_W-1:0] ch_write_data,
   output logic [NUM_CH-1:0]        ch_ack,
   output logic [DATA_W-1:0]        ch_read_data,
   output logic                     ch_err,
   output logic [NUM_CH-1:0]        grant,
   output logic                     busy,
   mem_arbiter_n_if.master          mem
);

   localparam int   PTR_W = ptr_width(NUM_CH);
   localparam logic FIXED = (ARB_MODE == ARB_MODE_FIXED);

   state_t            state, state_n;
   op_t               op, op_n;
   logic [PTR_W-1:0]  ptr, ptr_n, win, win_n;
   logic [ADDR_W-1:0] addr_r, addr_n;
   logic [DATA_W-1:0] wdata_r, wdata_n, rdata_r, rdata_n;
   logic              rd_r, rd_n, wr_r, wr_n, busy_r, busy_n, err_r, err_n;
   logic [NUM_CH-1:0] grant_r, grant_n, ack_r, ack_n;

   logic [NUM_CH-1:0] pick_oh;
   logic [PTR_W-1:0]  pick_idx;
   logic              pick_valid;
   logic              timeout;

   rr_pick #(.NUM_CH(NUM_CH), .PTR_W(PTR_W)) u_pick (
      .req    (ch_read_req | ch_write_req),
      .ptr    (ptr),
      .mode   (FIXED),
      .onehot (pick_oh),
      .idx    (pick_idx),
      .valid  (pick_valid)
   );

`ifdef MEM_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] cnt;

   // Counts ISSUE cycles; held at zero elsewhere so every grant starts fresh.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                cnt <= '0;
      else if (state == ISSUE)  cnt <= cnt + 1'b1;
      else                      cnt <= '0;
   end

   assign timeout = (state == ISSUE) && (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`else
   assign timeout = 1'b0;
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         op      <= OP_READ;
         ptr     <= '0;
         win     <= '0;
         addr_r  <= '0;
         wdata_r <= '0;
         rdata_r <= '0;
         rd_r    <= 1'b0;
         wr_r    <= 1'b0;
         busy_r  <= 1'b0;
         err_r   <= 1'b0;
         grant_r <= '0;
         ack_r   <= '0;
      end else begin
         state   <= state_n;
         op      <= op_n;
         ptr     <= ptr_n;
         win     <= win_n;
         addr_r  <= addr_n;
         wdata_r <= wdata_n;
         rdata_r <= rdata_n;
         rd_r    <= rd_n;
         wr_r    <= wr_n;
         busy_r  <= busy_n;
         err_r   <= err_n;
         grant_r <= grant_n;
         ack_r   <= ack_n;
      end
   end

   always_comb begin
      state_n = state;
      op_n    = op;
      ptr_n   = ptr;
      win_n   = win;
      addr_n  = addr_r;
      wdata_n = wdata_r;
      rd_n    = rd_r;
      wr_n    = wr_r;
      busy_n  = busy_r;
      grant_n = grant_r;
      rdata_n = '0;
      err_n   = 1'b0;
      ack_n   = '0;
      unique case (state)
         IDLE: begin
            if (pick_valid) begin
               // Write wins when a channel raises both; its read stays pending.
               op_n    = ch_write_req[pick_idx] ? OP_WRITE : OP_READ;
               win_n   = pick_idx;
               addr_n  = ch_addr[32'(pick_idx)*ADDR_W +: ADDR_W];
               wdata_n = ch_write_data[32'(pick_idx)*DATA_W +: DATA_W];
               rd_n    = !ch_write_req[pick_idx];
               wr_n    = ch_write_req[pick_idx];
               grant_n = pick_oh;
               busy_n  = 1'b1;
               state_n = ISSUE;
               if (!FIXED)
                  ptr_n = (pick_idx == PTR_W'(NUM_CH - 1)) ? '0 : pick_idx + 1'b1;
            end
         end
         ISSUE: begin
            if (mem.mem_ack || timeout) begin
               rd_n    = 1'b0;
               wr_n    = 1'b0;
               grant_n = '0;
               ack_n   = NUM_CH'(1) << win;
               err_n   = !mem.mem_ack;
               rdata_n = (mem.mem_ack && op == OP_READ) ? mem.mem_data_read : '0;
               state_n = DONE;
            end
         end
         DONE: begin
            busy_n  = 1'b0;
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign ch_ack             = ack_r;
   assign ch_read_data       = rdata_r;
   assign ch_err             = err_r;
   assign grant              = grant_r;
   assign busy               = busy_r;
   assign mem.mem_read       = rd_r;
   assign mem.mem_write      = wr_r;
   assign mem.mem_addr       = addr_r;
   assign mem.mem_data_write = wdata_r;

endmodule

// File: tb/tb_mem_arbiter_n.sv
// Scoreboard bench: 4-channel round-robin arbiter plus 2-channel fixed-priority arbiter.
module tb_mem_arbiter_n;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic [3:0]   rreq = '0, wreq = '0;
   logic [127:0] addr = '0, wdata = '0;
   logic [3:0]   ack, grant;
   logic [31:0]  rdata;
   logic         err, busy;

   logic [1:0]   frreq = '0;
   logic [1:0]   fack, fgrant;
   logic [31:0]  frdata;
   logic         ferr, fbusy;

   mem_arbiter_n_if #(.ADDR_W(32), .DATA_W(32)) mif ();
   mem_arbiter_n_if #(.ADDR_W(32), .DATA_W(32)) fif ();

   mem_arbiter_n #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .ARB_MODE(0), .TIMEOUT_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .ch_read_req(rreq), .ch_write_req(wreq),
      .ch_addr(addr), .ch_write_data(wdata), .ch_ack(ack), .ch_read_data(rdata),
      .ch_err(err), .grant(grant), .busy(busy), .mem(mif.master)
   );

   mem_arbiter_n #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .ARB_MODE(1), .TIMEOUT_CYCLES(8)) dfx (
      .clk(clk), .reset(reset), .ch_read_req(frreq), .ch_write_req(2'b00),
      .ch_addr(64'h0000_0024_0000_0020), .ch_write_data('0), .ch_ack(fack),
      .ch_read_data(frdata), .ch_err(ferr), .grant(fgrant), .busy(fbusy), .mem(fif.master)
   );

   int checks = 0, errors = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      return (a == 32'h100) ? 32'hDEAD_BEEF : ~a;
   endfunction

   typedef struct {
      logic [3:0]  oh;
      logic        wr;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      logic        e;
   } exp_t;

   exp_t       iss_q[$], ack_q[$];
   logic [1:0] fx_q[$];

   task automatic push_exp(input int ch, input logic wr, input logic [31:0] a,
                           input logic [31:0] wd, input logic timed_out);
      exp_t x;
      x.oh = 4'(1 << ch);
      x.wr = wr;
      x.a  = a;
      x.wd = wd;
      x.rd = (wr || timed_out) ? 32'h0 : mem_fn(a);
      x.e  = timed_out;
      iss_q.push_back(x);
      ack_q.push_back(x);
   endtask

   // Memory model: acks on the mem_lat-th strobe cycle; inject_ack forces a stray ack.
   int   mem_lat = 4;
   logic inject_ack = 1'b0;
   initial begin
      int scnt = 0;
      mif.mem_ack = 1'b0;
      mif.mem_data_read = '0;
      forever begin
         @(posedge clk); #1;
         if (mif.mem_ack) begin
            mif.mem_ack = 1'b0;
            scnt = 0;
         end else if (inject_ack) begin
            mif.mem_ack = 1'b1;
            mif.mem_data_read = 32'hBAD0_BAD0;
         end else if (mif.mem_read || mif.mem_write) begin
            scnt++;
            if (scnt == mem_lat) begin
               mif.mem_ack = 1'b1;
               mif.mem_data_read = mem_fn(mif.mem_addr);
            end
         end else scnt = 0;
      end
   end

   initial begin
      fif.mem_ack = 1'b0;
      fif.mem_data_read = '0;
      forever begin
         @(posedge clk); #1;
         if (fif.mem_ack) fif.mem_ack = 1'b0;
         else if (fif.mem_read) fif.mem_ack = 1'b1;
      end
   end

   int acks_seen = 0, last_slen = 0, fx_grants = 0;
   initial begin
      exp_t x;
      int slen = 0;
      logic [3:0] pg = '0, pa = '0;
      logic [1:0] fpg = '0;
      forever begin
         @(posedge clk); #1;
         if (reset) begin
            pg = '0; pa = '0; fpg = '0; slen = 0;
         end else begin
            if (grant != 0 && pg == 0) begin
               if (iss_q.size() == 0) check_eq("unexp_grant", grant, 0);
               else begin
                  x = iss_q.pop_front();
                  check_eq("grant", grant, x.oh);
                  check_eq("mem_addr", mif.mem_addr, x.a);
                  check_eq("mem_rw", {mif.mem_write, mif.mem_read}, x.wr ? 2'b10 : 2'b01);
                  if (x.wr) check_eq("mem_wdata", mif.mem_data_write, x.wd);
                  check_eq("busy_issue", busy, 1);
               end
            end
            if (mif.mem_read || mif.mem_write) slen++;
            if (pa != 0) check_eq("ack_pulse", ack, 0);
            if (ack != 0) begin
               acks_seen++;
               last_slen = slen;
               slen = 0;
               if (ack_q.size() == 0) check_eq("unexp_ack", ack, 0);
               else begin
                  x = ack_q.pop_front();
                  check_eq("ch_ack", ack, x.oh);
                  check_eq("ch_read_data", rdata, x.rd);
                  check_eq("ch_err", err, x.e);
                  check_eq("grant_clr", grant, 0);
               end
            end
            if (fgrant != 0 && fpg == 0) begin
               fx_grants++;
               if (fx_q.size() == 0) check_eq("fx_unexp", fgrant, 0);
               else check_eq("fx_grant", fgrant, fx_q.pop_front());
            end
            pg = grant; pa = ack; fpg = fgrant;
         end
      end
   end

   task automatic wait_acks(input int n, input int budget);
      int target = acks_seen + n;
      int c = 0;
      while (acks_seen < target && c < budget) begin
         @(posedge clk); #2;
         c++;
      end
      check_eq("ack_wait", 64'(acks_seen), 64'(target));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      rreq = '0; wreq = '0; frreq = '0;
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      iss_q.delete(); ack_q.delete(); fx_q.delete();
   endtask

   initial begin
      repeat (2) @(posedge clk); #2;
      check_eq("rst_grant", grant, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_strobes", {mif.mem_read, mif.mem_write}, 0);
      check_eq("rst_ack", ack, 0);
      check_eq("rst_rdata", rdata, 0);
      check_eq("rst_err", err, 0);
      check_eq("rst_addr", mif.mem_addr, 0);
      check_eq("rst_wdata", mif.mem_data_write, 0);
      reset = 1'b0;

      // Single read on ch0, ack on the 4th strobe cycle.
      mem_lat = 4;
      addr[0 +: 32] = 32'h100;
      push_exp(0, 1'b0, 32'h100, 32'h0, 1'b0);
      rreq[0] = 1'b1;
      wait_acks(1, 40);
      rreq[0] = 1'b0;
      check_eq("rd_strobe_len", 64'(last_slen), 4);

      // Write on ch1 while ch0 idle.
      mem_lat = 2;
      addr[32 +: 32] = 32'h40;
      wdata[32 +: 32] = 32'h55AA;
      push_exp(1, 1'b1, 32'h40, 32'h55AA, 1'b0);
      wreq[1] = 1'b1;
      wait_acks(1, 40);
      wreq[1] = 1'b0;

      // Requester drops mid-ISSUE; transaction still completes.
      mem_lat = 6;
      addr[96 +: 32] = 32'h300;
      push_exp(3, 1'b0, 32'h300, 32'h0, 1'b0);
      rreq[3] = 1'b1;
      repeat (3) @(posedge clk); #2;
      rreq[3] = 1'b0;
      wait_acks(1, 40);

      // Round-robin between two continuous readers.
      do_reset();
      mem_lat = 2;
      addr[0 +: 32] = 32'h10;
      addr[32 +: 32] = 32'h14;
      for (int i = 0; i < 4; i++) push_exp(i % 2, 1'b0, (i % 2 == 0) ? 32'h10 : 32'h14, 32'h0, 1'b0);
      rreq = 4'b0011;
      wait_acks(4, 80);
      rreq = '0;

      // All four channels: order 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < 4; i++) addr[i*32 +: 32] = 32'h1000 + 32'(i * 4);
      for (int i = 0; i < 5; i++) push_exp(i % 4, 1'b0, 32'h1000 + 32'((i % 4) * 4), 32'h0, 1'b0);
      rreq = 4'b1111;
      wait_acks(5, 100);
      rreq = '0;

      // Same channel read+write: write first, read later.
      do_reset();
      addr[64 +: 32] = 32'h2000;
      wdata[64 +: 32] = 32'h1234;
      push_exp(2, 1'b1, 32'h2000, 32'h1234, 1'b0);
      push_exp(2, 1'b0, 32'h2000, 32'h0, 1'b0);
      rreq[2] = 1'b1;
      wreq[2] = 1'b1;
      wait_acks(1, 40);
      wreq[2] = 1'b0;
      wait_acks(1, 40);
      rreq[2] = 1'b0;

      // Reset two cycles into ISSUE, then a stale ack.
      mem_lat = 1000;
      addr[0 +: 32] = 32'h500;
      push_exp(0, 1'b0, 32'h500, 32'h0, 1'b0);
      rreq[0] = 1'b1;
      for (int c = 0; c < 20 && !mif.mem_read; c++) begin
         @(posedge clk); #2;
      end
      check_eq("strobe_seen", mif.mem_read, 1);
      repeat (2) @(posedge clk); #2;
      reset = 1'b1;
      #1;
      check_eq("midrst_outs", {grant, busy, mif.mem_read, mif.mem_write, ack, err}, 0);
      check_eq("midrst_addr", mif.mem_addr, 0);
      rreq = '0;
      @(posedge clk); #2;
      reset = 1'b0;
      iss_q.delete(); ack_q.delete();
      @(negedge clk) inject_ack = 1'b1;
      @(negedge clk) inject_ack = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #2;
         check_eq("post_rst_idle", {busy, ack, grant, mif.mem_read}, 0);
      end

`ifdef MEM_ARB_TIMEOUT_EN
      // Memory never answers: abort after 8 ISSUE cycles.
      mem_lat = 1000;
      addr[0 +: 32] = 32'h600;
      push_exp(0, 1'b0, 32'h600, 32'h0, 1'b1);
      rreq[0] = 1'b1;
      wait_acks(1, 60);
      rreq[0] = 1'b0;
      check_eq("timeout_len", 64'(last_slen), 8);
`else
      // Slow memory: ISSUE waits well past TIMEOUT_CYCLES with no error.
      mem_lat = 20;
      addr[0 +: 32] = 32'h600;
      push_exp(0, 1'b0, 32'h600, 32'h0, 1'b0);
      rreq[0] = 1'b1;
      wait_acks(1, 60);
      rreq[0] = 1'b0;
      check_eq("stall_len", 64'(last_slen), 20);
`endif

      // Arbiter resumes normally afterwards.
      mem_lat = 3;
      addr[32 +: 32] = 32'h700;
      push_exp(1, 1'b0, 32'h700, 32'h0, 1'b0);
      rreq[1] = 1'b1;
      wait_acks(1, 40);
      rreq[1] = 1'b0;

      // Fixed priority: ch0 wins while requesting, then ch1.
      do_reset();
      repeat (3) fx_q.push_back(2'b01);
      fx_q.push_back(2'b10);
      frreq = 2'b11;
      for (int c = 0; c < 60 && fx_grants < 3; c++) begin
         @(posedge clk); #2;
      end
      frreq = 2'b10;
      for (int c = 0; c < 60 && fx_grants < 4; c++) begin
         @(posedge clk); #2;
      end
      frreq = 2'b00;
      check_eq("fx_count", 64'(fx_grants), 4);
      repeat (6) @(posedge clk); #2;
      check_eq("fx_idle", {fbusy, fgrant}, 0);
      check_eq("queues_empty", 64'(iss_q.size() + ack_q.size() + fx_q.size()), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
